// File: rtl/acquisition.sv
// Serial-search GPS L1 C/A acquisition engine.
// Sweeps PRN 1..32 and all 1023 code phases per PRN, correlating one code
// period of I/Q baseband against the local C/A code; sets a sticky flag per
// PRN whose non-coherent energy |accI|+|accQ| exceeds THRESHOLD.
module acquisition #(
    parameter int unsigned   SAMPLES_PER_CHIP = 4,
    parameter int unsigned   ACC_W            = 32,
    parameter logic [ACC_W:0] THRESHOLD       = (ACC_W + 1)'(200000)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic signed [15:0] i_in,
    input  logic signed [15:0] q_in,
    output logic [31:0]        detectedSAT
);

    localparam int unsigned CODE_LEN  = 1023;
    localparam int unsigned DWELL_LEN = CODE_LEN * SAMPLES_PER_CHIP;
    localparam int unsigned CNT_W     = $clog2(DWELL_LEN);
    localparam int unsigned CHIP_W    = (SAMPLES_PER_CHIP > 1) ? $clog2(SAMPLES_PER_CHIP) : 1;
    localparam int unsigned E_W       = ACC_W + 1;

    localparam logic [CNT_W-1:0]  DWELL_LAST = CNT_W'(DWELL_LEN - 1);
    localparam logic [CNT_W-1:0]  SLIP_LAST  = CNT_W'(SAMPLES_PER_CHIP - 1);
    localparam logic [CHIP_W-1:0] CHIP_LAST  = CHIP_W'(SAMPLES_PER_CHIP - 1);
    localparam logic [9:0]        LAST_PHASE = 10'd1022;
    localparam logic              HAS_SLIP   = (SAMPLES_PER_CHIP > 1);

    typedef enum logic [0:0] {
        ST_DWELL = 1'b0,
        ST_SLIP  = 1'b1
    } state_t;

    state_t                   state;
    logic [CNT_W-1:0]         cnt;
    logic [CHIP_W-1:0]        chip_cnt;
    logic                     eval;
    logic [4:0]               prn;
    logic [9:0]               phase;
    logic [9:0]               g1;
    logic [9:0]               g2;
    logic signed [ACC_W-1:0]  acc_i;
    logic signed [ACC_W-1:0]  acc_q;

    // G2 output taps {a-1, b-1} for PRN index (PRN-1)
    function automatic logic [7:0] g2_taps(input logic [4:0] idx);
        logic [7:0] t;
        t = '0;
        unique case (idx)
            5'd0:  t = {4'd1, 4'd5};
            5'd1:  t = {4'd2, 4'd6};
            5'd2:  t = {4'd3, 4'd7};
            5'd3:  t = {4'd4, 4'd8};
            5'd4:  t = {4'd0, 4'd8};
            5'd5:  t = {4'd1, 4'd9};
            5'd6:  t = {4'd0, 4'd7};
            5'd7:  t = {4'd1, 4'd8};
            5'd8:  t = {4'd2, 4'd9};
            5'd9:  t = {4'd1, 4'd2};
            5'd10: t = {4'd2, 4'd3};
            5'd11: t = {4'd4, 4'd5};
            5'd12: t = {4'd5, 4'd6};
            5'd13: t = {4'd6, 4'd7};
            5'd14: t = {4'd7, 4'd8};
            5'd15: t = {4'd8, 4'd9};
            5'd16: t = {4'd0, 4'd3};
            5'd17: t = {4'd1, 4'd4};
            5'd18: t = {4'd2, 4'd5};
            5'd19: t = {4'd3, 4'd6};
            5'd20: t = {4'd4, 4'd7};
            5'd21: t = {4'd5, 4'd8};
            5'd22: t = {4'd0, 4'd2};
            5'd23: t = {4'd3, 4'd5};
            5'd24: t = {4'd4, 4'd6};
            5'd25: t = {4'd5, 4'd7};
            5'd26: t = {4'd6, 4'd8};
            5'd27: t = {4'd7, 4'd9};
            5'd28: t = {4'd0, 4'd5};
            5'd29: t = {4'd1, 4'd6};
            5'd30: t = {4'd2, 4'd7};
            5'd31: t = {4'd3, 4'd8};
        endcase
        return t;
    endfunction

    logic [7:0]              taps;
    logic                    chip;
    logic [9:0]              g1_next;
    logic [9:0]              g2_next;
    logic signed [ACC_W-1:0] smp_i;
    logic signed [ACC_W-1:0] smp_q;
    logic signed [ACC_W-1:0] base_i;
    logic signed [ACC_W-1:0] base_q;
    logic [E_W-1:0]          ext_i;
    logic [E_W-1:0]          ext_q;
    logic [E_W-1:0]          mag_i;
    logic [E_W-1:0]          mag_q;
    logic [E_W-1:0]          energy;
    logic                    hit;

    // Local code: bit k-1 holds register stage k; output stage is bit 9
    assign taps    = g2_taps(prn);
    assign chip    = g1[9] ^ g2[taps[7:4]] ^ g2[taps[3:0]];
    assign g1_next = {g1[8:0], g1[2] ^ g1[9]};
    assign g2_next = {g2[8:0], g2[1] ^ g2[2] ^ g2[5] ^ g2[7] ^ g2[8] ^ g2[9]};

    // Sign-extended samples; a pending decision restarts the accumulation
    assign smp_i  = ACC_W'(i_in);
    assign smp_q  = ACC_W'(q_in);
    assign base_i = eval ? '0 : acc_i;
    assign base_q = eval ? '0 : acc_q;

    // Energy of the just-finished dwell, one bit wider so |most-negative| fits
    assign ext_i  = {acc_i[ACC_W-1], acc_i};
    assign ext_q  = {acc_q[ACC_W-1], acc_q};
    assign mag_i  = acc_i[ACC_W-1] ? (E_W'(0) - ext_i) : ext_i;
    assign mag_q  = acc_q[ACC_W-1] ? (E_W'(0) - ext_q) : ext_q;
    assign energy = mag_i + mag_q;
    assign hit    = eval && (energy > THRESHOLD);

    // Search sequencer, code generator, correlators and detection flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_DWELL;
            cnt         <= '0;
            chip_cnt    <= '0;
            eval        <= 1'b0;
            prn         <= '0;
            phase       <= '0;
            g1          <= '1;
            g2          <= '1;
            acc_i       <= '0;
            acc_q       <= '0;
            detectedSAT <= '0;
        end else begin
            unique case (state)
                ST_DWELL: begin
                    if (chip_cnt == CHIP_LAST) begin
                        chip_cnt <= '0;
                        g1       <= g1_next;
                        g2       <= g2_next;
                    end else begin
                        chip_cnt <= chip_cnt + CHIP_W'(1);
                    end
                    acc_i <= chip ? (base_i - smp_i) : (base_i + smp_i);
                    acc_q <= chip ? (base_q - smp_q) : (base_q + smp_q);
                    eval  <= (cnt == DWELL_LAST);
                    cnt   <= (cnt == DWELL_LAST) ? '0 : cnt + CNT_W'(1);
                    // Decision cycle: generator has wrapped to its seed here,
                    // so this sample is chip 0 of whatever comes next
                    if (eval) begin
                        if (hit) begin
                            detectedSAT[prn] <= 1'b1;
                        end
                        if (hit || phase == LAST_PHASE) begin
                            prn   <= prn + 5'd1;
                            phase <= '0;
                        end else begin
                            phase    <= phase + 10'd1;
                            acc_i    <= '0;
                            acc_q    <= '0;
                            g1       <= '1;
                            g2       <= '1;
                            chip_cnt <= '0;
                            state    <= HAS_SLIP ? ST_SLIP : ST_DWELL;
                            cnt      <= HAS_SLIP ? CNT_W'(1) : '0;
                        end
                    end
                end
                ST_SLIP: begin
                    if (cnt == SLIP_LAST) begin
                        state <= ST_DWELL;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_acquisition.sv
// Directed bench for acquisition: two instances (4 and 1 samples/chip) share
// one clock; expected flag vectors are queued per cycle and checked on arrival.
module tb_acquisition;

    localparam longint THR = 200000;
    localparam int     N1  = 1023;

    logic               clk = 1'b0;
    logic               rst4;
    logic               rst1;
    logic signed [15:0] i4, q4, i1, q1;
    logic [31:0]        det4, det1;

    always #5 clk = ~clk;

    acquisition #(.SAMPLES_PER_CHIP(4)) dut4 (
        .clk(clk), .reset(rst4), .i_in(i4), .q_in(q4), .detectedSAT(det4));
    acquisition #(.SAMPLES_PER_CHIP(1)) dut1 (
        .clk(clk), .reset(rst1), .i_in(i1), .q_in(q1), .detectedSAT(det1));

    typedef struct {
        int          cyc;
        logic [31:0] exp;
        string       tag;
    } exp_t;

    exp_t        sb4[$];
    exp_t        sb1[$];
    bit          code_tab [1:32][0:1022];
    int          ta [1:32] = '{2,3,4,5,1,2,1,2,3,2,3,5,6,7,8,9,1,2,3,4,5,6,1,4,5,6,7,8,1,2,3,4};
    int          tb [1:32] = '{6,7,8,9,9,10,8,9,10,3,4,6,7,8,9,10,4,5,6,7,8,9,3,6,7,8,9,10,6,7,8,9};
    int          t4, t1, p4, dly4, amp4, ext4;
    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] head;
    logic [31:0] xp;

    // Reference C/A generator with stage arrays indexed 1..10
    task automatic build_codes();
        bit g1 [1:10];
        bit g2 [1:10];
        bit f1, f2;
        for (int p = 1; p <= 32; p++) begin
            for (int k = 1; k <= 10; k++) begin g1[k] = 1'b1; g2[k] = 1'b1; end
            for (int c = 0; c < N1; c++) begin
                code_tab[p][c] = g1[10] ^ g2[ta[p]] ^ g2[tb[p]];
                f1 = g1[3] ^ g1[10];
                f2 = g2[2] ^ g2[3] ^ g2[6] ^ g2[8] ^ g2[9] ^ g2[10];
                for (int k = 10; k >= 2; k--) begin g1[k] = g1[k-1]; g2[k] = g2[k-1]; end
                g1[1] = f1;
                g2[1] = f2;
            end
        end
    endtask

    // BPSK sample: chip 0 -> +amp, chip 1 -> -amp; first 'extra' samples get +1 amplitude
    function automatic logic signed [15:0] samp(int prn, int t, int spc, int dly, int amp, int extra);
        int c;
        int a;
        if (prn == 0) return 16'sd0;
        c = ((t / spc) - dly) % N1;
        if (c < 0) c += N1;
        a = amp + ((t < extra) ? 1 : 0);
        return code_tab[prn][c] ? 16'(-a) : 16'(a);
    endfunction

    // Energy of a zero-offset dwell of local PRN lp against input PRN ip
    function automatic longint corr_energy(int lp, int ip, int amp, int spc);
        longint s = 0;
        for (int c = 0; c < N1; c++) s += (code_tab[lp][c] == code_tab[ip][c]) ? 1 : -1;
        if (s < 0) s = -s;
        return s * amp * spc;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push4(input int cyc, input logic [31:0] exp, input string tag);
        exp_t e;
        e.cyc = cyc; e.exp = exp; e.tag = tag;
        sb4.push_back(e);
    endtask

    task automatic push1(input int cyc, input logic [31:0] exp, input string tag);
        exp_t e;
        e.cyc = cyc; e.exp = exp; e.tag = tag;
        sb1.push_back(e);
    endtask

    // One clock: drive both streams, then check any expectation due this cycle
    task automatic tick();
        exp_t e;
        if (!rst4) begin
            i4 = 16'($urandom);
            q4 = 16'($urandom);
        end else begin
            i4 = samp(p4, t4, 4, dly4, amp4, ext4);
            q4 = 16'sd0;
        end
        i1 = (t1 < 33 * N1) ? samp((t1 / N1) % 32 + 1, t1, 1, 0, 1000, 0) : 16'sd0;
        q1 = 16'sd0;
        @(posedge clk);
        #1;
        if (rst4) begin
            while (sb4.size() > 0 && sb4[0].cyc == t4) begin
                e = sb4.pop_front();
                chk(e.tag, det4, e.exp);
            end
            t4++;
        end
        if (rst1) begin
            while (sb1.size() > 0 && sb1[0].cyc == t1) begin
                e = sb1.pop_front();
                chk(e.tag, det1, e.exp);
            end
            t1++;
        end
    endtask

    task automatic run_to4(input int last);
        while (t4 <= last) tick();
    endtask

    // Asynchronous reset of the 4-sample/chip instance between clock edges
    task automatic reset4();
        rst4 = 1'b0;
        #2;
        chk("reset_async", det4, 32'h0);
        repeat (2) tick();
        t4   = 0;
        rst4 = 1'b1;
    endtask

    initial begin
        exp_t e;
        build_codes();
        head = '0;
        for (int k = 0; k < 10; k++) head = {head[30:0], code_tab[1][k]};
        chk("prn1_head", head, 32'h320);

        rst4 = 1'b0; rst1 = 1'b0;
        t4 = 0; t1 = 0; p4 = 0; dly4 = 0; amp4 = 0; ext4 = 0;
        repeat (6) tick();
        chk("reset_hold4", det4, 32'h0);
        chk("reset_hold1", det1, 32'h0);

        // 1 sample/chip: dwell d carries PRN d+1 aligned, then PRN1 again after wrap
        for (int d = 0; d < 32; d++) begin
            push1(N1 * (d + 1) - 1, 32'((64'd1 << d) - 64'd1), $sformatf("chain_pre%0d", d + 1));
            push1(N1 * (d + 1), 32'((64'd1 << (d + 1)) - 64'd1), $sformatf("chain_hit%0d", d + 1));
        end
        push1(N1 * 33, 32'hFFFF_FFFF, "chain_wrap");
        rst1 = 1'b1;

        // Zero input: nothing detected over two dwells
        rst4 = 1'b1;
        push4(4092, 32'h0, "zero_d1");
        push4(8188, 32'h0, "zero_d2");
        run_to4(8190);
        reset4();

        // Aligned PRN1 at 1000: hit after first dwell, PRN2 dwell follows
        p4 = 1; dly4 = 0; amp4 = 1000; ext4 = 0;
        xp = (corr_energy(2, 1, 1000, 4) > THR) ? 32'h3 : 32'h1;
        push4(4091, 32'h0, "aligned_pre");
        push4(4092, 32'h1, "aligned_hit");
        push4(8184, xp, "aligned_prn2");
        push4(8190, xp, "aligned_hold");
        run_to4(8190);
        reset4();

        // PRN1 delayed by 5 chips: found on dwell 6 only
        p4 = 1; dly4 = 5; amp4 = 100;
        push4(4092, 32'h0, "delay_d1");
        push4(3 * 4096 + 4092, 32'h0, "delay_d4");
        push4(5 * 4096 + 4091, 32'h0, "delay_pre");
        push4(5 * 4096 + 4092, 32'h1, "delay_hit");
        run_to4(5 * 4096 + 4093);
        reset4();

        // Threshold boundary: E == THRESHOLD misses, E == THRESHOLD+1 hits
        dly4 = 0; amp4 = 48; ext4 = 3584;
        push4(4092, 32'h0, "thr_equal");
        push4(4093, 32'h0, "thr_equal_hold");
        run_to4(4093);
        reset4();
        ext4 = 3585;
        push4(4091, 32'h0, "thr_plus1_pre");
        push4(4092, 32'h1, "thr_plus1");
        run_to4(4093);
        reset4();

        // PRN7 signal against local PRN1
        p4 = 7; amp4 = 1000; ext4 = 0;
        xp = (corr_energy(1, 7, 1000, 4) > THR) ? 32'h1 : 32'h0;
        push4(4092, xp, "wrong_prn");
        run_to4(4093);

        while (t1 <= N1 * 33 + 1) tick();

        while (sb4.size() > 0) begin
            e = sb4.pop_front();
            n_vec++; n_bad++;
            $error("FAIL %s: never reached, expected %h", e.tag, e.exp);
        end
        while (sb1.size() > 0) begin
            e = sb1.pop_front();
            n_vec++; n_bad++;
            $error("FAIL %s: never reached, expected %h", e.tag, e.exp);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/acquisition.md
Name: acquisition

Overview:
- Serial-search GPS L1 C/A acquisition engine fed with baseband complex samples (I/Q, one sample pair per clock).
- For PRN 1..32 in turn, correlates one full code period against a locally generated C/A code, sweeping all 1023 chip phases.
- Sets a sticky per-PRN detection flag when non-coherent correlation magnitude exceeds a threshold.
- Sits after the front-end sample interface; its flag vector feeds the spoofer's satellite-selection logic.

Parameters:
- SAMPLES_PER_CHIP, 4, input samples per C/A chip (≥1).
- ACC_W, 32, signed width of each I/Q accumulator.
- THRESHOLD, 32'd200000, detection threshold on |accI|+|accQ| (unsigned, ACC_W+1 bits).

Ports:
- clk  in  1  system clock; one I/Q sample consumed per rising edge.
- reset  in  1  asynchronous, active-low reset.
- i_in  in  16  signed two's-complement in-phase sample.
- q_in  in  16  signed two's-complement quadrature sample.
- detectedSAT  out  32  bit n-1 = PRN n detected (sticky).

Behaviour:
- Reset (reset=0, async): detectedSAT=0, PRN index=1, phase count=0, accumulators=0, G1=G2=10'b1111111111, chip-sample counter=0, state=DWELL.
- Code generator:
  - G1 = 1+x^3+x^10; G2 = 1+x^2+x^3+x^6+x^8+x^9+x^10; both seeded with all ones.
  - chip = G1[10] ^ G2[a] ^ G2[b], with (a,b) per PRN: 1(2,6) 2(3,7) 3(4,8) 4(5,9) 5(1,9) 6(2,10) 7(1,8) 8(2,9) 9(3,10) 10(2,3) 11(3,4) 12(5,6) 13(6,7) 14(7,8) 15(8,9) 16(9,10) 17(1,4) 18(2,5) 19(3,6) 20(4,7) 21(5,8) 22(6,9) 23(1,3) 24(4,6) 25(5,7) 26(6,8) 27(7,9) 28(8,10) 29(1,6) 30(2,7) 31(3,8) 32(4,9).
  - Registers shift once every SAMPLES_PER_CHIP active cycles.
  - Period is 1023 chips; PRN1's first 10 chips are 1100100000.
- DWELL state:
  - Lasts exactly 1023*SAMPLES_PER_CHIP cycles.
  - Each cycle: if chip=0, accI+=i_in and accQ+=q_in; if chip=1, subtract.
  - Sign-extend to ACC_W; wrap on overflow, no saturation.
- Dwell end (pipelined, no gap):
  - On the cycle after the last sample, the final accI/accQ are latched and E=|accI|+|accQ| is formed.
  - The accumulators restart with the current sample when the next state is DWELL.
- Decision uses strict comparison E > THRESHOLD:
  - Hit: detectedSAT[PRN-1] is set on the next edge. Advance to the next PRN, reseed generators, phase count=0, start DWELL immediately. Local chip 0 of the new PRN aligns to that cycle.
  - Miss with phase count < 1022: increment phase count and enter SLIP.
  - Miss with phase count = 1022 (all 1023 phases tried): advance PRN as on a hit, with no flag.
- SLIP state:
  - Lasts SAMPLES_PER_CHIP cycles; generator is held and samples are discarded.
  - This delays local code by exactly one chip relative to the input stream.
  - Then returns to DWELL with accumulators cleared.
- PRN advance wraps 32→1; search runs forever.
- Flags are never cleared except by reset. A re-detection of an already-set PRN leaves it set.
- The first sample after reset release aligns with local chip 0 of PRN1, phase 0.
- Reset asserted mid-dwell or mid-slip aborts immediately to reset values.
- Single always-running datapath; no valid/ready handshake. Inputs are sampled every cycle.

Test Plan:
- Reset: hold reset=0 with random i_in/q_in → detectedSAT=0; after release with zero input for 5 full PRN sweeps → detectedSAT stays 0.
- Aligned PRN1: after reset release, i_in=+1000 for chip 0 / −1000 for chip 1 of PRN1 (SAMPLES_PER_CHIP=4), q_in=0 → E=4,092,000 > THRESHOLD. detectedSAT=32'h1 on the edge after sample 4092; the search then moves to PRN2 and bit1 stays 0.
- Delayed PRN1, k=5 chips: input sample t carries chip ((t div 4)−5) mod 1023, generated continuously from reset release → bit0 set at the end of dwell 6, not before.
- Threshold boundary: choose amplitude so E==THRESHOLD → no detection; E==THRESHOLD+1 → bit0 set.
- Wrong PRN: continuous PRN7 signal with SAMPLES_PER_CHIP=1 → only bit6 is set after the PRN1..6 sweeps complete; bits 0..5 stay 0.
- Reset mid-operation: assert reset after bit0 is set and mid-dwell → detectedSAT=0 asynchronously; the search restarts at PRN1, phase 0.
